// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//   Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment
//   display. Each digit gets a slot of DIV clocks: BLANK clocks with every
//   anode off (anti-ghosting guard), then the rest of the slot driving that
//   digit. Nibbles decode to active-low hex segments, with optional
//   leading-zero blanking. New values are taken through a load strobe and
//   applied only at frame boundaries so a frame never shows a mix of values.
//
// Parameters
//   NDIG   number of digits (1..8)
//   DIV    clk cycles per digit slot (blank + drive), DIV > BLANK
//   BLANK  clk cycles of all-anodes-off at the start of each slot, >= 1
//
// Ports
//   clk        in   clock
//   rst        in   asynchronous reset, active-low
//   load       in   1-cycle strobe: capture din/dp_in
//   din        in   hex nibbles, [3:0] = digit 0 (least significant)
//   dp_in      in   decimal point per digit, 1 = lit
//   lzb_en     in   leading-zero blanking enable (sampled live)
//   an         out  digit enables, active-low
//   segd       out  segments {g,f,e,d,c,b,a}, active-low
//   dp         out  decimal point, active-low
//   frame_done out  1-cycle pulse when digit NDIG-1's slot ends
//   pending    out  a captured value waits for the next frame boundary
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
    parameter int NDIG  = 4,
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [4*NDIG-1:0]   din,
    input  logic [NDIG-1:0]     dp_in,
    input  logic                lzb_en,
    output logic [NDIG-1:0]     an,
    output logic [6:0]          segd,
    output logic                dp,
    output logic                frame_done,
    output logic                pending
);

    localparam int CW = (DIV  > 1) ? $clog2(DIV)  : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic [4*NDIG-1:0]   disp_nib;
    logic [NDIG-1:0]     disp_dp;
    logic [4*NDIG-1:0]   pend_nib;
    logic [NDIG-1:0]     pend_dp;

    logic                slot_end;
    logic                frame_end;
    logic [CW-1:0]       cnt_nxt;
    logic [NDIG-1:0]     zero_run;
    logic                acc;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_zero_run;
    logic                lead_blank;
    logic [NDIG-1:0]     an_nxt;
    logic [6:0]          segd_nxt;
    logic                dp_nxt;

    // Active-low hex decode, {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign slot_end  = (cnt == CW'(DIV - 1));
    assign frame_end = slot_end && (idx == IW'(NDIG - 1));
    assign cnt_nxt   = slot_end ? '0 : cnt + 1'b1;

    always_comb begin
        zero_run     = '0;
        acc          = 1'b1;
        cur_nib      = '0;
        cur_dp       = 1'b0;
        cur_zero_run = 1'b0;
        an_nxt       = '1;
        segd_nxt     = 7'h7F;
        dp_nxt       = 1'b1;

        // zero_run[i]: nibbles i..NDIG-1 of the display buffer are all zero,
        // built from the most significant digit downwards.
        for (int unsigned k = 0; k < NDIG; k++) begin
            acc = acc & (disp_nib[4*(NDIG-1-k) +: 4] == 4'h0);
            zero_run[NDIG-1-k] = acc;
        end

        for (int unsigned k = 0; k < NDIG; k++) begin
            if (idx == IW'(k)) begin
                cur_nib      = disp_nib[4*k +: 4];
                cur_dp       = disp_dp[k];
                cur_zero_run = zero_run[k];
            end
        end

        // Digit 0 always shows, so a value of zero still displays "0".
        lead_blank = lzb_en && (idx != '0) && cur_zero_run;

        if (state == ST_DRIVE) begin
            for (int unsigned k = 0; k < NDIG; k++) begin
                if (idx == IW'(k)) begin
                    an_nxt[k] = 1'b0;
                end
            end
            segd_nxt = lead_blank ? 7'h7F : hex7(cur_nib);
            dp_nxt   = ~cur_dp;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_BLANK;
            cnt        <= '0;
            idx        <= '0;
            disp_nib   <= '0;
            disp_dp    <= '0;
            pend_nib   <= '0;
            pend_dp    <= '0;
            pending    <= 1'b0;
            an         <= '1;
            segd       <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            state <= (cnt_nxt < CW'(BLANK)) ? ST_BLANK : ST_DRIVE;

            if (slot_end) begin
                idx <= (idx == IW'(NDIG - 1)) ? '0 : idx + 1'b1;
            end

            frame_done <= frame_end;

            // At the boundary a same-cycle load bypasses the pending buffer,
            // since it is newer than anything waiting there.
            if (frame_end) begin
                if (load) begin
                    disp_nib <= din;
                    disp_dp  <= dp_in;
                    pending  <= 1'b0;
                end else if (pending) begin
                    disp_nib <= pend_nib;
                    disp_dp  <= pend_dp;
                    pending  <= 1'b0;
                end
            end else if (load) begin
                pend_nib <= din;
                pend_dp  <= dp_in;
                pending  <= 1'b1;
            end

            an   <= an_nxt;
            segd <= segd_nxt;
            dp   <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;

    localparam int NDIG  = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = DIV * NDIG;

    logic            clk;
    logic            rst;
    logic            load;
    logic [15:0]     din;
    logic [3:0]      dp_in;
    logic            lzb_en;
    logic [3:0]      an;
    logic [6:0]      segd;
    logic            dp;
    logic            frame_done;
    logic            pending;

    int checks = 0;
    int errors = 0;

    seg7_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .BLANK(BLANK)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .din        (din),
        .dp_in      (dp_in),
        .lzb_en     (lzb_en),
        .an         (an),
        .segd       (segd),
        .dp         (dp),
        .frame_done (frame_done),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: mpos is the position within the frame (0..FRAME-1)
    // counted in clocks since reset; digit = mpos / DIV, slot time = mpos % DIV.
    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int          mpos;
    logic [15:0] m_disp, m_pbuf;
    logic [3:0]  m_ddp, m_pdp;
    logic        m_pend;
    logic [3:0]  exp_an;
    logic [6:0]  exp_segd;
    logic        exp_dp;
    logic        exp_fd;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mpos     <= 0;
            m_disp   <= '0;
            m_pbuf   <= '0;
            m_ddp    <= '0;
            m_pdp    <= '0;
            m_pend   <= 1'b0;
            exp_an   <= 4'hF;
            exp_segd <= 7'h7F;
            exp_dp   <= 1'b1;
            exp_fd   <= 1'b0;
        end else begin
            if (mpos % DIV < BLANK) begin
                exp_an   <= 4'hF;
                exp_segd <= 7'h7F;
                exp_dp   <= 1'b1;
            end else begin
                exp_an   <= ~(4'b0001 << (mpos / DIV));
                exp_segd <= (lzb_en && (mpos / DIV) != 0 &&
                             (m_disp >> (4 * (mpos / DIV))) == 16'h0000)
                            ? 7'h7F : seg_tab[m_disp[4*(mpos/DIV) +: 4]];
                exp_dp   <= ~m_ddp[mpos / DIV];
            end
            exp_fd <= (mpos == FRAME - 1);
            if (mpos == FRAME - 1) begin
                if (load) begin
                    m_disp <= din;
                    m_ddp  <= dp_in;
                    m_pend <= 1'b0;
                end else if (m_pend) begin
                    m_disp <= m_pbuf;
                    m_ddp  <= m_pdp;
                    m_pend <= 1'b0;
                end
            end else if (load) begin
                m_pbuf <= din;
                m_pdp  <= dp_in;
                m_pend <= 1'b1;
            end
            mpos <= (mpos + 1) % FRAME;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Literal expectation applied to both DUT and model.
    task automatic lit(input string name, input logic [15:0] dut_v,
                       input logic [15:0] mdl_v, input logic [15:0] req);
        chk({name, " dut"}, dut_v, req);
        chk({name, " model"}, mdl_v, req);
    endtask

    // Continuous comparison against the model on every falling edge.
    always @(negedge clk) begin
        chk("an", 16'(an), 16'(exp_an));
        chk("segd", 16'(segd), 16'(exp_segd));
        chk("dp", 16'(dp), 16'(exp_dp));
        chk("frame_done", 16'(frame_done), 16'(exp_fd));
        chk("pending", 16'(pending), 16'(m_pend));
    end

    // Advance to the falling edge whose outputs reflect frame position p.
    task automatic goto(input int p);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((mpos + FRAME - 1) % FRAME) != p && n < 200);
        if (n >= 200) begin
            errors++;
            checks++;
            $display("FAIL goto: position %0d not reached within 200 cycles", p);
        end
    endtask

    task automatic pulse(input logic [15:0] v, input logic [3:0] d);
        load  = 1'b1;
        din   = v;
        dp_in = d;
        @(negedge clk);
        load  = 1'b0;
    endtask

    logic [15:0] mask;

    initial begin
        rst    = 1'b0;
        load   = 1'b0;
        din    = '0;
        dp_in  = '0;
        lzb_en = 1'b0;
        repeat (2) @(negedge clk);
        lit("rst an", 16'(an), 16'(exp_an), 16'hF);
        lit("rst segd", 16'(segd), 16'(exp_segd), 16'h7F);
        lit("rst dp", 16'(dp), 16'(exp_dp), 16'h1);
        lit("rst fd", 16'(frame_done), 16'(exp_fd), 16'h0);
        lit("rst pending", 16'(pending), 16'(m_pend), 16'h0);
        rst = 1'b1;

        // Free-running scan with an all-zero buffer
        goto(0);  lit("blank0 an", 16'(an), 16'(exp_an), 16'hF);
        goto(2);  lit("dig0 an", 16'(an), 16'(exp_an), 16'hE);
                  lit("dig0 segd", 16'(segd), 16'(exp_segd), 16'h40);
        goto(8);  lit("blank1 an", 16'(an), 16'(exp_an), 16'hF);
        goto(10); lit("dig1 an", 16'(an), 16'(exp_an), 16'hD);
        goto(18); lit("dig2 an", 16'(an), 16'(exp_an), 16'hB);
        goto(26); lit("dig3 an", 16'(an), 16'(exp_an), 16'h7);
        goto(30); lit("fd low", 16'(frame_done), 16'(exp_fd), 16'h0);
        goto(31); lit("fd high", 16'(frame_done), 16'(exp_fd), 16'h1);

        // Mid-frame load held until the boundary
        goto(5);  pulse(16'h12AF, 4'b0100);
        lit("pend set", 16'(pending), 16'(m_pend), 16'h1);
        goto(10); lit("old dig1", 16'(segd), 16'(exp_segd), 16'h40);
        goto(2);  lit("new dig0", 16'(segd), 16'(exp_segd), 16'h0E);
        goto(10); lit("new dig1", 16'(segd), 16'(exp_segd), 16'h08);
        goto(18); lit("new dig2", 16'(segd), 16'(exp_segd), 16'h24);
                  lit("new dp2", 16'(dp), 16'(exp_dp), 16'h0);
        goto(26); lit("new dig3", 16'(segd), 16'(exp_segd), 16'h79);
                  lit("pend clr", 16'(pending), 16'(m_pend), 16'h0);

        // Two loads in one frame: last one wins
        goto(3);  pulse(16'h0001, 4'b0000);
        goto(12); pulse(16'h0002, 4'b0000);
        lit("pend 2x", 16'(pending), 16'(m_pend), 16'h1);
        goto(2);  lit("last wins", 16'(segd), 16'(exp_segd), 16'h24);
                  lit("pend 2x clr", 16'(pending), 16'(m_pend), 16'h0);

        // Leading-zero blanking
        lzb_en = 1'b1;
        goto(4);  pulse(16'h0050, 4'b0000);
        goto(2);  lit("lzb d0", 16'(segd), 16'(exp_segd), 16'h40);
        goto(10); lit("lzb d1", 16'(segd), 16'(exp_segd), 16'h12);
        goto(18); lit("lzb d2", 16'(segd), 16'(exp_segd), 16'h7F);
                  lit("lzb d2 an", 16'(an), 16'(exp_an), 16'hB);
        goto(26); lit("lzb d3", 16'(segd), 16'(exp_segd), 16'h7F);
        goto(4);  pulse(16'h0000, 4'b0000);
        goto(2);  lit("lzb0 d0", 16'(segd), 16'(exp_segd), 16'h40);
        goto(10); lit("lzb0 d1", 16'(segd), 16'(exp_segd), 16'h7F);

        // Load on the boundary cycle itself
        goto(30); pulse(16'h0003, 4'b0000);
        lit("bnd pend", 16'(pending), 16'(m_pend), 16'h0);
        goto(2);  lit("bnd d0", 16'(segd), 16'(exp_segd), 16'h30);

        // Asynchronous reset during digit 2 drive
        goto(20);
        #2 rst = 1'b0;
        #1;
        lit("arst an", 16'(an), 16'(exp_an), 16'hF);
        lit("arst segd", 16'(segd), 16'(exp_segd), 16'h7F);
        @(negedge clk);
        rst = 1'b1;
        goto(2);  lit("post rst an", 16'(an), 16'(exp_an), 16'hE);
                  lit("post rst segd", 16'(segd), 16'(exp_segd), 16'h40);

        // Randomized traffic checked by the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            case ($urandom_range(0, 3))
                0:       mask = 16'h000F;
                1:       mask = 16'h00FF;
                2:       mask = 16'h0FFF;
                default: mask = 16'hFFFF;
            endcase
            load  = ($urandom_range(0, 7) == 0);
            din   = 16'($urandom) & mask;
            dp_in = 4'($urandom);
            if ($urandom_range(0, 15) == 0) lzb_en = ~lzb_en;
            if ($urandom_range(0, 999) == 0) begin
                load = 1'b0;
                rst  = 1'b0;
                @(negedge clk);
                rst  = 1'b1;
            end
        end
        load = 1'b0;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
